// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBC = 2'b11
  } op_t;

  localparam int GROUP_MIN = 2;
  localparam int GROUP_MAX = 8;

  function automatic int ngrp(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_group.sv
// One lookahead group: group generate/propagate plus the carry into every bit,
// each carry built as a flat sum of products rather than a ripple chain.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_g,
  input  logic [GROUP-1:0] i_p,
  input  logic             i_cin,
  output logic             o_gg,
  output logic             o_pg,
  output logic [GROUP-1:0] o_carry
);

  // Carry into bit i = OR over j<i of g[j]&p[i-1..j+1], plus p[i-1..0]&cin.
  always_comb begin
    logic v_acc;
    logic v_term;
    v_acc   = 1'b0;
    v_term  = 1'b0;
    o_carry = '0;
    for (int i = 0; i < GROUP; i++) begin
      v_acc = i_cin;
      for (int m = 0; m < i; m++) v_acc = v_acc & i_p[m];
      for (int j = 0; j < i; j++) begin
        v_term = i_g[j];
        for (int m = j + 1; m < i; m++) v_term = v_term & i_p[m];
        v_acc = v_acc | v_term;
      end
      o_carry[i] = v_acc;
    end
    o_gg = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      v_term = i_g[j];
      for (int m = j + 1; m < GROUP; m++) v_term = v_term & i_p[m];
      o_gg = o_gg | v_term;
    end
    o_pg = &i_p;
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage valid/ready carry-lookahead adder/subtractor with cascadable group G/P.
// Optional overflow/zero flags are built only when CLA_FLAGS_EN is defined.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter  int WIDTH = 36,
  parameter  int GROUP = 4,
  localparam int NGRP  = ngrp(WIDTH, GROUP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [NGRP-1:0]  out_gg,
  output logic [NGRP-1:0]  out_pg,
  output logic             out_ovf,
  output logic             out_zero
);

  if ((WIDTH % GROUP) != 0) begin : g_badWidth
    $error("cla_adder_pipe: WIDTH %0d is not a multiple of GROUP %0d", WIDTH, GROUP);
  end
  if ((GROUP < GROUP_MIN) || (GROUP > GROUP_MAX)) begin : g_badGroup
    $error("cla_adder_pipe: GROUP %0d outside legal range", GROUP);
  end

  logic             w_s1Adv;
  logic             w_s2Adv;
  logic [WIDTH-1:0] w_eb;
  logic             w_ec;
  logic [NGRP-1:0]  w_s1Gg;
  logic [NGRP-1:0]  w_s1Pg;
  logic [WIDTH-1:0] w_unusedS1Carry;

  logic             r_s1Valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_eb;
  logic             r_ec;
  logic [NGRP-1:0]  r_gg;
  logic [NGRP-1:0]  r_pg;

  logic [NGRP:0]    w_gc;
  logic [NGRP-1:0]  w_s2Gg;
  logic [NGRP-1:0]  w_s2Pg;
  logic [WIDTH-1:0] w_bitC;
  logic [WIDTH-1:0] w_sum;

  logic             r_outValid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [NGRP-1:0]  r_outGg;
  logic [NGRP-1:0]  r_outPg;

  assign w_s2Adv  = !r_outValid || out_ready;
  assign w_s1Adv  = !r_s1Valid || w_s2Adv;
  assign in_ready = w_s1Adv;

  // Subtraction is a + ~b + 1; the borrow variants take the carry from in_cin.
  always_comb begin
    w_eb = in_b;
    w_ec = 1'b0;
    case (in_op)
      OP_ADD:  w_ec = 1'b0;
      OP_ADC:  w_ec = in_cin;
      OP_SUB:  begin w_eb = ~in_b; w_ec = 1'b1;   end
      OP_SBC:  begin w_eb = ~in_b; w_ec = in_cin; end
      default: w_ec = 1'b0;
    endcase
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_s1Grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_g     (in_a[k*GROUP +: GROUP] & w_eb[k*GROUP +: GROUP]),
      .i_p     (in_a[k*GROUP +: GROUP] | w_eb[k*GROUP +: GROUP]),
      .i_cin   (1'b0),
      .o_gg    (w_s1Gg[k]),
      .o_pg    (w_s1Pg[k]),
      .o_carry (w_unusedS1Carry[k*GROUP +: GROUP])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_a       <= '0;
      r_eb      <= '0;
      r_ec      <= 1'b0;
      r_gg      <= '0;
      r_pg      <= '0;
    end else if (w_s1Adv) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_a  <= in_a;
        r_eb <= w_eb;
        r_ec <= w_ec;
        r_gg <= w_s1Gg;
        r_pg <= w_s1Pg;
      end
    end
  end

  // Second-level lookahead: every group carry-in is a flat product-sum of GG/PG.
  always_comb begin
    logic v_acc;
    logic v_term;
    v_acc  = 1'b0;
    v_term = 1'b0;
    w_gc   = '0;
    for (int k = 0; k <= NGRP; k++) begin
      v_acc = r_ec;
      for (int m = 0; m < k; m++) v_acc = v_acc & r_pg[m];
      for (int j = 0; j < k; j++) begin
        v_term = r_gg[j];
        for (int m = j + 1; m < k; m++) v_term = v_term & r_pg[m];
        v_acc = v_acc | v_term;
      end
      w_gc[k] = v_acc;
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_s2Grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_g     (r_a[k*GROUP +: GROUP] & r_eb[k*GROUP +: GROUP]),
      .i_p     (r_a[k*GROUP +: GROUP] | r_eb[k*GROUP +: GROUP]),
      .i_cin   (w_gc[k]),
      .o_gg    (w_s2Gg[k]),
      .o_pg    (w_s2Pg[k]),
      .o_carry (w_bitC[k*GROUP +: GROUP])
    );
  end

  assign w_sum = r_a ^ r_eb ^ w_bitC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_outGg    <= '0;
      r_outPg    <= '0;
    end else if (w_s2Adv) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_sum   <= w_sum;
        r_cout  <= w_gc[NGRP];
        r_outGg <= w_s2Gg;
        r_outPg <= w_s2Pg;
      end
    end
  end

`ifdef CLA_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_s2Adv && r_s1Valid) begin
      r_ovf  <= (r_a[WIDTH-1] == r_eb[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      r_zero <= (w_sum == '0);
    end
  end

  assign out_ovf  = r_ovf;
  assign out_zero = r_zero;
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

  assign out_valid = r_outValid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_gg    = r_outGg;
  assign out_pg    = r_outPg;

endmodule
